ula_arb_seq: RTL and testbench

- Shares one combinational ULA (ALU) between two requesters, e.g. the execute stage and the address/branch unit.
- Arbitrates the requests and latches the winner's operands and opcode onto the ULA inputs.
- Waits one settle cycle, then registers the result and O/C/S/Z flags and acknowledges the winner.
- Sits between the requesters and the ULA instance; the ULA itself stays outside this block.

---
 rtl/ula_arb_seq_if.sv | 51 +++++
 rtl/ula_arb_seq.sv | 145 ++++++++++++++
 tb/tb_ula_arb_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_arb_seq_if.sv
// Bus bundle for ula_arb_seq: two requester ports, the ULA operand/result
// path and the registered result/flag outputs.
// The arbiter connects through the slave modport; the environment (requesters
// and ULA) drives the other side through the master modport.
interface ula_arb_seq_if #(
  parameter int BITS = 16,
  parameter int OPW  = 5
);
  logic            REQ0;
  logic [BITS-1:0] A0;
  logic [BITS-1:0] B0;
  logic [OPW-1:0]  OP0;
  logic            ACK0;

  logic            REQ1;
  logic [BITS-1:0] A1;
  logic [BITS-1:0] B1;
  logic [OPW-1:0]  OP1;
  logic            ACK1;

  logic [BITS-1:0] ULA_A;
  logic [BITS-1:0] ULA_B;
  logic [OPW-1:0]  ULA_OP;
  logic [BITS-1:0] ULA_RESU;
  logic            ULA_O;
  logic            ULA_C;
  logic            ULA_S;
  logic            ULA_Z;

  logic [BITS-1:0] RESU;
  logic            O;
  logic            C;
  logic            S;
  logic            Z;
  logic            GNT;
  logic            BUSY;

  modport slave (
    input  REQ0, A0, B0, OP0, REQ1, A1, B1, OP1,
    input  ULA_RESU, ULA_O, ULA_C, ULA_S, ULA_Z,
    output ACK0, ACK1, ULA_A, ULA_B, ULA_OP,
    output RESU, O, C, S, Z, GNT, BUSY
  );

  modport master (
    output REQ0, A0, B0, OP0, REQ1, A1, B1, OP1,
    output ULA_RESU, ULA_O, ULA_C, ULA_S, ULA_Z,
    input  ACK0, ACK1, ULA_A, ULA_B, ULA_OP,
    input  RESU, O, C, S, Z, GNT, BUSY
  );
endinterface

// File: rtl/ula_arb_seq.sv
// ula_arb_seq: shares one external combinational ULA between two requesters.
// IDLE picks a winner and latches its operands, EXEC gives the ULA a settle
// cycle and captures result/flags, DONE pulses the winner's ACK.
// Optional macro ULA_ARB_SEQ_FIXPRIO_EN: requester 0 always wins a tie
// (fixed priority). Without it, ties are resolved round robin.
module ula_arb_seq #(
  parameter int BITS = 16,
  parameter int OPW  = 5
) (
  input logic        CLK,
  input logic        RST,
  ula_arb_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            grant;
  logic            winner;

  logic [BITS-1:0] ula_a_q;
  logic [BITS-1:0] ula_b_q;
  logic [OPW-1:0]  ula_op_q;
  logic [BITS-1:0] resu_q;
  logic            o_q;
  logic            c_q;
  logic            s_q;
  logic            z_q;
  logic            gnt_q;
  logic [1:0]      ack_q;

`ifndef ULA_ARB_SEQ_FIXPRIO_EN
  logic            last_q;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and winner selection; a grant only happens from IDLE.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          grant     = 1'b1;
          state_nxt = EXEC;
          if (bus.REQ0 && bus.REQ1) begin
`ifdef ULA_ARB_SEQ_FIXPRIO_EN
            winner = 1'b0;
`else
            winner = ~last_q;
`endif
          end else begin
            winner = bus.REQ1;
          end
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/opcode latch to the ULA; sampled only on the grant edge and held
  // otherwise, so requesters may change their inputs after being granted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ula_a_q  <= '0;
      ula_b_q  <= '0;
      ula_op_q <= '0;
      gnt_q    <= 1'b0;
    end else if (grant) begin
      ula_a_q  <= winner ? bus.A1  : bus.A0;
      ula_b_q  <= winner ? bus.B1  : bus.B0;
      ula_op_q <= winner ? bus.OP1 : bus.OP0;
      gnt_q    <= winner;
    end
  end

`ifndef ULA_ARB_SEQ_FIXPRIO_EN
  // Round-robin memory; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= winner;
    end
  end
`endif

  // Result and flag capture at the end of the settle cycle; held elsewhere.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resu_q <= '0;
      o_q    <= 1'b0;
      c_q    <= 1'b0;
      s_q    <= 1'b0;
      z_q    <= 1'b0;
    end else if (state == EXEC) begin
      resu_q <= bus.ULA_RESU;
      o_q    <= bus.ULA_O;
      c_q    <= bus.ULA_C;
      s_q    <= bus.ULA_S;
      z_q    <= bus.ULA_Z;
    end
  end

  // One-cycle ACK to the granted requester, valid while in DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_q <= 2'b00;
    end else if (state == EXEC) begin
      ack_q <= {gnt_q, ~gnt_q};
    end else begin
      ack_q <= 2'b00;
    end
  end

  assign bus.ULA_A  = ula_a_q;
  assign bus.ULA_B  = ula_b_q;
  assign bus.ULA_OP = ula_op_q;
  assign bus.RESU   = resu_q;
  assign bus.O      = o_q;
  assign bus.C      = c_q;
  assign bus.S      = s_q;
  assign bus.Z      = z_q;
  assign bus.GNT    = gnt_q;
  assign bus.ACK0   = ack_q[0];
  assign bus.ACK1   = ack_q[1];
  assign bus.BUSY   = (state != IDLE);

endmodule

// File: tb/tb_ula_arb_seq.sv
// Testbench for ula_arb_seq: a stub ULA, a directed vector table, hand-written
// multi-cycle sequences and randomized transactions checked against a
// transaction-level arbitration model.
module tb_ula_arb_seq;

  localparam int BITS = 16;
  localparam int OPW  = 5;

  logic CLK = 1'b0;
  logic RST;

  ula_arb_seq_if #(.BITS(BITS), .OPW(OPW)) bus ();

  ula_arb_seq #(.BITS(BITS), .OPW(OPW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [15:0] perturb;
  logic        model_last;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [4:0]  op0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [4:0]  op1;
    logic        first;
    logic [15:0] res_first;
    logic [15:0] res_second;
  } vec_t;

  vec_t vt[6];

  // Reference ULA behaviour: returns {O, C, S, Z, result}.
  function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] op);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        o;
    w = '0;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      5'd1: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'd2: begin
        r = a - b;
        c = (a < b);
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      5'd3:    r = a & b;
      5'd4:    r = a | b;
      default: r = a ^ b;
    endcase
    return {o, c, r[15], (r == 16'h0000), r};
  endfunction

  // Stub ULA; perturb lets the bench wiggle the ULA outputs while idle.
  logic [19:0] stub_u;
  assign stub_u       = ref_alu(bus.ULA_A, bus.ULA_B, bus.ULA_OP);
  assign bus.ULA_RESU = stub_u[15:0] ^ perturb;
  assign bus.ULA_Z    = stub_u[16] ^ perturb[0];
  assign bus.ULA_S    = stub_u[17] ^ perturb[1];
  assign bus.ULA_C    = stub_u[18] ^ perturb[2];
  assign bus.ULA_O    = stub_u[19] ^ perturb[3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge CLK);
    #1;
  endtask

  // Winner the arbitration rules give for a request pattern seen in IDLE.
  function automatic logic model_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ULA_ARB_SEQ_FIXPRIO_EN
      return 1'b0;
`else
      return ~model_last;
`endif
    end
    return r1;
  endfunction

  // Drive one request pattern from IDLE, collect every ACK and compare it.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   need;
    int   got;
    logic exp_w;
    need = int'(v.r0) + int'(v.r1);
    got  = 0;
    bus.REQ0 = v.r0; bus.A0 = v.a0; bus.B0 = v.b0; bus.OP0 = v.op0;
    bus.REQ1 = v.r1; bus.A1 = v.a1; bus.B1 = v.b1; bus.OP1 = v.op1;
    for (int cyc = 0; cyc < 20 && got < need; cyc++) begin
      waitCycle();
      if (bus.ACK0 || bus.ACK1) begin
        exp_w = (got == 0) ? v.first : ~v.first;
        checkOutput({tag, "_ack"}, {bus.ACK1, bus.ACK0}, exp_w ? 2'b10 : 2'b01);
        checkOutput({tag, "_gnt"}, bus.GNT, exp_w);
        checkOutput({tag, "_resu"}, bus.RESU, (got == 0) ? v.res_first : v.res_second);
        checkOutput({tag, "_ula_a"}, bus.ULA_A, exp_w ? v.a1 : v.a0);
        checkOutput({tag, "_ula_op"}, bus.ULA_OP, exp_w ? v.op1 : v.op0);
        if (bus.ACK0) bus.REQ0 = 1'b0;
        if (bus.ACK1) bus.REQ1 = 1'b0;
        got++;
      end
    end
    if (got < need) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got %0d acks expected %0d", tag, got, need);
    end
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    if (need == 2) model_last = ~v.first;
    else           model_last = v.first;
    waitCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  mask;
    int          ng;
    logic        rr_last;
    logic        exp_w;
    logic        w;
    logic        drop0;
    logic        drop1;
    vec_t        rv;
    logic [19:0] u0;
    logic [19:0] u1;

    RST = 1'b1;
    perturb = '0;
    bus.REQ0 = 1'b0; bus.A0 = '0; bus.B0 = '0; bus.OP0 = '0;
    bus.REQ1 = 1'b0; bus.A1 = '0; bus.B1 = '0; bus.OP1 = '0;
    model_last = 1'b1;

    vt[0] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 5'd2, 16'h00F0, 16'h0F0F, 5'd3, 1'b0, 16'h000F, 16'h0000};
    vt[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 5'd0, 16'h1234, 16'h0001, 5'd1, 1'b1, 16'h1235, 16'h0000};
    vt[2] = '{1'b1, 1'b1, 16'hFF00, 16'h00FF, 5'd4, 16'h8000, 16'h8000, 5'd1, 1'b0, 16'hFFFF, 16'h0000};
    vt[3] = '{1'b1, 1'b0, 16'hAAAA, 16'h5555, 5'd5, 16'h0000, 16'h0000, 5'd0, 1'b0, 16'hFFFF, 16'h0000};
`ifdef ULA_ARB_SEQ_FIXPRIO_EN
    vt[4] = '{1'b1, 1'b1, 16'h0001, 16'h0002, 5'd1, 16'h0005, 16'h0007, 5'd2, 1'b0, 16'h0003, 16'hFFFE};
`else
    vt[4] = '{1'b1, 1'b1, 16'h0001, 16'h0002, 5'd1, 16'h0005, 16'h0007, 5'd2, 1'b1, 16'hFFFE, 16'h0003};
`endif
    vt[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 5'd0, 16'h7FFF, 16'h0001, 5'd1, 1'b1, 16'h8000, 16'h0000};

    // Reset state while reset is held.
    #2;
    checkOutput("rst_busy", bus.BUSY, 1'b0);
    checkOutput("rst_acks", {bus.ACK1, bus.ACK0}, 2'b00);
    checkOutput("rst_resu", bus.RESU, 16'h0000);
    checkOutput("rst_ula", {bus.ULA_A, bus.ULA_B, bus.ULA_OP}, 37'h0);
    @(negedge CLK);
    RST = 1'b0;
    waitCycle();

    // Single operation with exact ACK timing.
    bus.REQ0 = 1'b1; bus.A0 = 16'h0003; bus.B0 = 16'h0004; bus.OP0 = 5'h01;
    waitCycle();
    checkOutput("single_ula_a", bus.ULA_A, 16'h0003);
    checkOutput("single_ula_b", bus.ULA_B, 16'h0004);
    checkOutput("single_ula_op", bus.ULA_OP, 5'h01);
    checkOutput("single_busy", bus.BUSY, 1'b1);
    checkOutput("single_ack_early", bus.ACK0, 1'b0);
    waitCycle();
    checkOutput("single_ack0", bus.ACK0, 1'b1);
    checkOutput("single_ack1", bus.ACK1, 1'b0);
    checkOutput("single_resu", bus.RESU, 16'h0007);
    checkOutput("single_gnt", bus.GNT, 1'b0);
    checkOutput("single_zc", {bus.Z, bus.C}, 2'b00);
    bus.REQ0 = 1'b0;
    waitCycle();
    checkOutput("single_ack_pulse", bus.ACK0, 1'b0);
    checkOutput("single_busy_end", bus.BUSY, 1'b0);
    model_last = 1'b0;

    // Flag capture and hold while the ULA outputs move.
    bus.REQ0 = 1'b1; bus.A0 = 16'hFFFF; bus.B0 = 16'h0001; bus.OP0 = 5'h01;
    waitCycle();
    waitCycle();
    checkOutput("flag_ack", bus.ACK0, 1'b1);
    checkOutput("flag_resu", bus.RESU, 16'h0000);
    checkOutput("flag_ocsz", {bus.O, bus.C, bus.S, bus.Z}, 4'b0101);
    bus.REQ0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      perturb = 16'hF00F ^ 16'(i);
      waitCycle();
      checkOutput("flag_hold", {bus.O, bus.C, bus.S, bus.Z, bus.RESU}, {4'b0101, 16'h0000});
    end
    perturb = '0;

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_rst_flags", {bus.O, bus.C, bus.S, bus.Z}, 4'b0000);
    checkOutput("async_rst_ula", {bus.ULA_A, bus.ULA_B, bus.ULA_OP}, 37'h0);
    checkOutput("async_rst_misc", {bus.GNT, bus.BUSY, bus.ACK0, bus.ACK1, bus.RESU}, 20'h0);
    @(negedge CLK);
    RST = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      checkOutput("idle_no_ack", {bus.ACK1, bus.ACK0}, 2'b00);
    end

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vt[i], $sformatf("vec%0d", i));
    end

    // Contention: both held, each dropped for one cycle after its ACK.
    bus.REQ0 = 1'b1; bus.A0 = 16'h0011; bus.B0 = 16'h0022; bus.OP0 = 5'd1;
    bus.REQ1 = 1'b1; bus.A1 = 16'h0033; bus.B1 = 16'h0044; bus.OP1 = 5'd1;
    ng = 0;
    rr_last = model_last;
    drop0 = 1'b0;
    drop1 = 1'b0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      waitCycle();
      if (drop0) begin bus.REQ0 = 1'b1; drop0 = 1'b0; end
      if (drop1) begin bus.REQ1 = 1'b1; drop1 = 1'b0; end
      if (bus.ACK0 || bus.ACK1) begin
        w = bus.ACK1;
`ifdef ULA_ARB_SEQ_FIXPRIO_EN
        exp_w = 1'b0;
`else
        exp_w = ~rr_last;
`endif
        checkOutput($sformatf("contention_order%0d", ng), w, exp_w);
        rr_last = exp_w;
        if (w) begin bus.REQ1 = 1'b0; drop1 = 1'b1; end
        else   begin bus.REQ0 = 1'b0; drop0 = 1'b1; end
        ng++;
      end
    end
    if (ng < 4) begin
      checks++;
      failures++;
      $display("[TB] FAIL contention_timeout: got %0d grants expected 4", ng);
    end
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    waitCycle();
    waitCycle();
    model_last = rr_last;

    // Operand isolation after the grant edge.
    bus.REQ1 = 1'b1; bus.A1 = 16'h00AA; bus.B1 = 16'h0001; bus.OP1 = 5'd1;
    waitCycle();
    checkOutput("iso_ula_a_grant", bus.ULA_A, 16'h00AA);
    bus.A1 = 16'h0055;
    waitCycle();
    checkOutput("iso_ack1", bus.ACK1, 1'b1);
    checkOutput("iso_ula_a_exec", bus.ULA_A, 16'h00AA);
    checkOutput("iso_resu", bus.RESU, 16'h00AB);
    bus.REQ1 = 1'b0;
    waitCycle();
    waitCycle();
    checkOutput("iso_ula_a_idle", bus.ULA_A, 16'h00AA);
    model_last = 1'b1;

    // Reset during EXEC, then a fresh request completes normally.
    bus.REQ0 = 1'b1; bus.A0 = 16'h0100; bus.B0 = 16'h0001; bus.OP0 = 5'd2;
    waitCycle();
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midrst_ack", {bus.ACK1, bus.ACK0}, 2'b00);
    checkOutput("midrst_busy", bus.BUSY, 1'b0);
    checkOutput("midrst_resu", bus.RESU, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    model_last = 1'b1;
    bus.A0 = 16'h0020; bus.B0 = 16'h0003; bus.OP0 = 5'd1;
    waitCycle();
    checkOutput("midrst_post_ack_early", bus.ACK0, 1'b0);
    checkOutput("midrst_post_ula_a", bus.ULA_A, 16'h0020);
    waitCycle();
    checkOutput("midrst_post_ack", bus.ACK0, 1'b1);
    checkOutput("midrst_post_resu", bus.RESU, 16'h0023);
    bus.REQ0 = 1'b0;
    waitCycle();
    checkOutput("midrst_post_ack_pulse", bus.ACK0, 1'b0);
    model_last = 1'b0;

    // Randomized transactions against the arbitration model.
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      rv.r0  = mask[0];
      rv.r1  = mask[1];
      rv.a0  = 16'($urandom);
      rv.b0  = 16'($urandom);
      rv.op0 = 5'($urandom_range(0, 7));
      rv.a1  = 16'($urandom);
      rv.b1  = 16'($urandom);
      rv.op1 = 5'($urandom_range(0, 7));
      rv.first = model_winner(rv.r0, rv.r1);
      u0 = ref_alu(rv.a0, rv.b0, rv.op0);
      u1 = ref_alu(rv.a1, rv.b1, rv.op1);
      rv.res_first  = rv.first ? u1[15:0] : u0[15:0];
      rv.res_second = rv.first ? u0[15:0] : u1[15:0];
      applyStimulus(rv, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) waitCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
